// File: rtl/hazard_ctrl.sv
// ============================================================================
// hazard_ctrl : pipeline stall/flush arbiter with data-memory watchdog
// Revision    : 1.0
// ============================================================================
`default_nettype none

module hazard_ctrl #(
  parameter int XLEN        = 32,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [4:0]       ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_redirect,
  input  logic             if_ready,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_pause,
  output logic             if_id_pause,
  output logic             if_id_bubble,
  output logic             id_ex_pause,
  output logic             id_ex_bubble,
  output logic             ex_mem_pause,
  output logic             ex_mem_bubble,
  output logic             mem_wb_pause,
  output logic             mem_wb_bubble,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [1:0]       c_ST_RUN    = 2'd0;
  localparam logic [1:0]       c_ST_WAIT   = 2'd1;
  localparam logic [1:0]       c_ST_HALT   = 2'd2;
  localparam logic [15:0]      c_WAIT_LAST = 16'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] c_CNT_MAX   = '1;

  generate
    if (XLEN < 1 || MEM_TIMEOUT < 1 || MEM_TIMEOUT > 65535 || CNT_W < 1) begin : g_bad_params
      $error("hazard_ctrl: illegal parameter value");
    end
  endgenerate

  logic [1:0]       state_q, state_d;
  logic [15:0]      wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_cycles_q, flush_count_q;
  logic             w_mstall;
  logic             w_load_use;
  logic             w_flush_sel;

  assign w_mstall   = mem_req & ~mem_ready;
  assign w_load_use = ex_is_load & (ex_rd != 5'd0) &
                      ((id_rs1_used & (id_rs1 == ex_rd)) |
                       (id_rs2_used & (id_rs2 == ex_rd)));

  // Fixed-priority decision; reset overrides everything so the pipeline drains.
  always_comb begin
    pc_pause      = 1'b0;
    if_id_pause   = 1'b0;
    if_id_bubble  = 1'b0;
    id_ex_pause   = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_pause  = 1'b0;
    ex_mem_bubble = 1'b0;
    mem_wb_pause  = 1'b0;
    mem_wb_bubble = 1'b0;
    w_flush_sel   = 1'b0;
    if (reset) begin
      if_id_bubble  = 1'b1;
      id_ex_bubble  = 1'b1;
      ex_mem_bubble = 1'b1;
      mem_wb_bubble = 1'b1;
    end else if (state_q == c_ST_HALT) begin
      pc_pause     = 1'b1;
      if_id_pause  = 1'b1;
      id_ex_pause  = 1'b1;
      ex_mem_pause = 1'b1;
      mem_wb_pause = 1'b1;
    end else if (w_mstall) begin
      pc_pause      = 1'b1;
      if_id_pause   = 1'b1;
      id_ex_pause   = 1'b1;
      ex_mem_pause  = 1'b1;
      mem_wb_bubble = 1'b1;
    end else if (ex_redirect) begin
      if_id_bubble = 1'b1;
      id_ex_bubble = 1'b1;
      w_flush_sel  = 1'b1;
    end else if (w_load_use) begin
      pc_pause     = 1'b1;
      if_id_pause  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (!if_ready) begin
      pc_pause     = 1'b1;
      if_id_bubble = 1'b1;
    end
  end

  always_comb begin
    wait_cnt_d = w_mstall ? wait_cnt_q + 16'd1 : 16'd0;
    state_d    = state_q;
    if (state_q != c_ST_HALT) begin
      if (w_mstall && wait_cnt_q == c_WAIT_LAST) state_d = c_ST_HALT;
      else if (w_mstall)                         state_d = c_ST_WAIT;
      else                                       state_d = c_ST_RUN;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= c_ST_RUN;
      wait_cnt_q     <= 16'd0;
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (pc_pause && stall_cycles_q != c_CNT_MAX)
        stall_cycles_q <= stall_cycles_q + 1'b1;
      if (w_flush_sel && flush_count_q != c_CNT_MAX)
        flush_count_q <= flush_count_q + 1'b1;
    end
  end

  assign halted       = (state_q == c_ST_HALT);
  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// tb_hazard_ctrl : scoreboard bench, directed cases then random stimulus
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

  localparam int MT = 4;
  localparam int CW = 3;
  localparam int CMAX = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset;
  logic [4:0]    id_rs1, id_rs2, ex_rd;
  logic          id_rs1_used, id_rs2_used, ex_is_load, ex_redirect;
  logic          if_ready, mem_req, mem_ready;
  logic          pc_pause, if_id_pause, if_id_bubble, id_ex_pause, id_ex_bubble;
  logic          ex_mem_pause, ex_mem_bubble, mem_wb_pause, mem_wb_bubble, halted;
  logic [CW-1:0] stall_cycles, flush_count;

  hazard_ctrl #(.XLEN(32), .MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_redirect(ex_redirect), .if_ready(if_ready),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_pause(pc_pause), .if_id_pause(if_id_pause), .if_id_bubble(if_id_bubble),
    .id_ex_pause(id_ex_pause), .id_ex_bubble(id_ex_bubble),
    .ex_mem_pause(ex_mem_pause), .ex_mem_bubble(ex_mem_bubble),
    .mem_wb_pause(mem_wb_pause), .mem_wb_bubble(mem_wb_bubble),
    .halted(halted), .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [8:0] ctl;     // {pc, ifid p/b, idex p/b, exmem p/b, memwb p/b}
    logic       halted;
    logic [CW-1:0] sc;
    logic [CW-1:0] fc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Reference model state: abstract counts, not a state encoding.
  bit m_halted;
  int m_consec;
  int m_sc, m_fc;

  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("ctl", {pc_pause, if_id_pause, if_id_bubble, id_ex_pause, id_ex_bubble,
                  ex_mem_pause, ex_mem_bubble, mem_wb_pause, mem_wb_bubble}, e.ctl);
      chk("halted", {8'd0, halted}, {8'd0, e.halted});
      chk("stall_cycles", 9'(stall_cycles), 9'(e.sc));
      chk("flush_count", 9'(flush_count), 9'(e.fc));
      cyc++;
    end
  end

  // One cycle: compute expected from the rule table, push, then advance the model.
  task automatic tick();
    exp_t e;
    bit   mstall, lu, redir_sel;
    mstall = mem_req && !mem_ready;
    lu = ex_is_load && ex_rd != 0 &&
         ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
    redir_sel = 0;
    if (reset)            e.ctl = 9'b0_01_01_01_01;
    else if (m_halted)    e.ctl = 9'b1_10_10_10_10;
    else if (mstall)      e.ctl = 9'b1_10_10_10_01;
    else if (ex_redirect) begin e.ctl = 9'b0_01_01_00_00; redir_sel = 1; end
    else if (lu)          e.ctl = 9'b1_10_01_00_00;
    else if (!if_ready)   e.ctl = 9'b1_01_00_00_00;
    else                  e.ctl = 9'b0;
    e.halted = m_halted;
    e.sc = CW'(m_sc);
    e.fc = CW'(m_fc);
    exp_q.push_back(e);
    @(posedge clock);
    if (reset) begin
      m_halted = 0; m_consec = 0; m_sc = 0; m_fc = 0;
    end else begin
      if (e.ctl[8] && m_sc < CMAX) m_sc++;
      if (redir_sel && m_fc < CMAX) m_fc++;
      if (!m_halted) begin
        m_consec = mstall ? m_consec + 1 : 0;
        if (m_consec == MT) m_halted = 1;
      end
    end
    #1;
  endtask

  task automatic idle();
    reset = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
    ex_rd = 0; ex_is_load = 0; ex_redirect = 0; if_ready = 1; mem_req = 0; mem_ready = 0;
  endtask

  initial begin
    idle();
    reset = 1;
    @(posedge clock); #1;
    // reset held, then released
    reset = 1; tick(); tick();
    idle(); tick(); tick();
    // load-use on rs2, then same with ex_rd=0
    ex_is_load = 1; ex_rd = 5; id_rs2 = 5; id_rs2_used = 1; tick();
    ex_rd = 0; id_rs2 = 0; tick();
    idle(); tick();
    // memory stall masks redirect, redirect taken once memory completes
    mem_req = 1; mem_ready = 0; ex_redirect = 1; tick(); tick(); tick();
    mem_ready = 1; tick();
    idle(); tick();
    // redirect beats load-use and fetch stall
    ex_redirect = 1; ex_is_load = 1; ex_rd = 7; id_rs1 = 7; id_rs1_used = 1; if_ready = 0; tick();
    idle(); tick();
    // watchdog: MT stalled cycles then halt; memory completion does not leave halt
    reset = 1; tick(); idle();
    mem_req = 1; mem_ready = 0;
    repeat (MT + 2) tick();
    mem_ready = 1; tick(); tick();
    reset = 1; tick(); idle(); tick();
    // counter saturation
    if_ready = 0; repeat (10) tick();
    idle(); tick();
    // random phase
    for (int i = 0; i < 600; i++) begin
      reset       = ($urandom_range(0, 39) == 0) || (m_halted && $urandom_range(0, 5) == 0);
      id_rs1      = 5'($urandom_range(0, 3));
      id_rs2      = 5'($urandom_range(0, 3));
      ex_rd       = 5'($urandom_range(0, 3));
      id_rs1_used = 1'($urandom);
      id_rs2_used = 1'($urandom);
      ex_is_load  = 1'($urandom);
      ex_redirect = ($urandom_range(0, 3) == 0);
      if_ready    = ($urandom_range(0, 3) != 0);
      mem_req     = 1'($urandom);
      mem_ready   = ($urandom_range(0, 2) != 0);
      tick();
    end
    idle();
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clock);
    #1;
    if (exp_q.size() > 0) begin
      checks++; errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
